// File: rtl/rvc_fetch_aligner.sv
// ============================================================================
// rvc_fetch_aligner / rvc_decoder : halfword-queue fetch aligner with RVC expansion
// Rev 1.0
// ============================================================================
`default_nettype none

module rvc_decoder (
  input  logic [15:0] instr,
  input  logic        is_rv64,
  output logic [31:0] expanded,
  output logic        illegal
);
  logic [15:0] c;
  logic [4:0]  rd, rs2, rdp, rs1p;
  logic [5:0]  shamt;
  logic [20:0] jimm;

  assign c     = instr;
  assign rd    = c[11:7];
  assign rs2   = c[6:2];
  assign rdp   = {2'b01, c[4:2]};
  assign rs1p  = {2'b01, c[9:7]};
  assign shamt = {c[12], c[6:2]};
  assign jimm  = {{10{c[12]}}, c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};

  always_comb begin
    expanded = 32'h0000_0000;
    illegal  = 1'b0;
    case ({c[1:0], c[15:13]})
      5'b00_000: begin
        expanded = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'd2, 3'b000, rdp, 7'h13};
        illegal  = (c[12:5] == 8'h00);
      end
      5'b00_010: expanded = {5'b0, c[5], c[12:10], c[6], 2'b00, rs1p, 3'b010, rdp, 7'h03};
      5'b00_011: begin
        expanded = {4'b0, c[6:5], c[12:10], 3'b000, rs1p, 3'b011, rdp, 7'h03};
        illegal  = !is_rv64;
      end
      5'b00_110: expanded = {5'b0, c[5], c[12], rdp, rs1p, 3'b010, c[11:10], c[6], 2'b00, 7'h23};
      5'b00_111: begin
        expanded = {4'b0, c[6:5], c[12], rdp, rs1p, 3'b011, c[11:10], 3'b000, 7'h23};
        illegal  = !is_rv64;
      end
      5'b01_000: expanded = {{7{c[12]}}, c[6:2], rd, 3'b000, rd, 7'h13};
      5'b01_001: begin
        if (is_rv64) begin
          expanded = {{7{c[12]}}, c[6:2], rd, 3'b000, rd, 7'h1B};
          illegal  = (rd == 5'd0);
        end else begin
          expanded = {jimm[20], jimm[10:1], jimm[11], jimm[19:12], 5'd1, 7'h6F};
        end
      end
      5'b01_010: expanded = {{7{c[12]}}, c[6:2], 5'd0, 3'b000, rd, 7'h13};
      5'b01_011: begin
        illegal = (shamt == 6'd0);
        if (rd == 5'd2)
          expanded = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0, 5'd2, 3'b000, 5'd2, 7'h13};
        else
          expanded = {{15{c[12]}}, c[6:2], rd, 7'h37};
      end
      5'b01_100: begin
        case (c[11:10])
          2'b00: begin
            expanded = {6'b000000, shamt, rs1p, 3'b101, rs1p, 7'h13};
            illegal  = !is_rv64 && c[12];
          end
          2'b01: begin
            expanded = {6'b010000, shamt, rs1p, 3'b101, rs1p, 7'h13};
            illegal  = !is_rv64 && c[12];
          end
          2'b10: expanded = {{7{c[12]}}, c[6:2], rs1p, 3'b111, rs1p, 7'h13};
          default: begin
            case ({c[12], c[6:5]})
              3'b000: expanded = {7'h20, rdp, rs1p, 3'b000, rs1p, 7'h33};
              3'b001: expanded = {7'h00, rdp, rs1p, 3'b100, rs1p, 7'h33};
              3'b010: expanded = {7'h00, rdp, rs1p, 3'b110, rs1p, 7'h33};
              3'b011: expanded = {7'h00, rdp, rs1p, 3'b111, rs1p, 7'h33};
              3'b100: begin
                expanded = {7'h20, rdp, rs1p, 3'b000, rs1p, 7'h3B};
                illegal  = !is_rv64;
              end
              3'b101: begin
                expanded = {7'h00, rdp, rs1p, 3'b000, rs1p, 7'h3B};
                illegal  = !is_rv64;
              end
              default: illegal = 1'b1;
            endcase
          end
        endcase
      end
      5'b01_101: expanded = {jimm[20], jimm[10:1], jimm[11], jimm[19:12], 5'd0, 7'h6F};
      5'b01_110: expanded = {{4{c[12]}}, c[6:5], c[2], 5'd0, rs1p, 3'b000, c[11:10], c[4:3], c[12], 7'h63};
      5'b01_111: expanded = {{4{c[12]}}, c[6:5], c[2], 5'd0, rs1p, 3'b001, c[11:10], c[4:3], c[12], 7'h63};
      5'b10_000: begin
        expanded = {6'b000000, shamt, rd, 3'b001, rd, 7'h13};
        illegal  = !is_rv64 && c[12];
      end
      5'b10_010: begin
        expanded = {4'b0, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, rd, 7'h03};
        illegal  = (rd == 5'd0);
      end
      5'b10_011: begin
        expanded = {3'b0, c[4:2], c[12], c[6:5], 3'b000, 5'd2, 3'b011, rd, 7'h03};
        illegal  = !is_rv64 || (rd == 5'd0);
      end
      5'b10_100: begin
        if (!c[12]) begin
          if (rs2 == 5'd0) begin
            expanded = {12'h000, rd, 3'b000, 5'd0, 7'h67};
            illegal  = (rd == 5'd0);
          end else begin
            expanded = {7'h00, rs2, 5'd0, 3'b000, rd, 7'h33};
          end
        end else if (rs2 == 5'd0) begin
          expanded = (rd == 5'd0) ? 32'h0010_0073 : {12'h000, rd, 3'b000, 5'd1, 7'h67};
        end else begin
          expanded = {7'h00, rs2, rd, 3'b000, rd, 7'h33};
        end
      end
      5'b10_110: expanded = {4'b0, c[8:7], c[12], rs2, 5'd2, 3'b010, c[11:9], 2'b00, 7'h23};
      5'b10_111: begin
        expanded = {3'b0, c[9:7], c[12], rs2, 5'd2, 3'b011, c[11:10], 3'b000, 7'h23};
        illegal  = !is_rv64;
      end
      default: illegal = 1'b1;
    endcase
  end
endmodule

module rvc_fetch_aligner #(
  parameter int             XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            is_rv64,
  input  logic            fetch_valid,
  output logic            fetch_ready,
  input  logic [31:0]     fetch_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr_data,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_is_compressed,
  output logic            instr_illegal
);
  logic [15:0]     hw      [4];
  logic [15:0]     hw_next [4];
  logic [2:0]      count, consumed, appended, kept;
  logic [XLEN-1:0] head_pc;
  logic            drop_low, head_is32, fire;
  logic [31:0]     dec_data;
  logic            dec_illegal;
  logic            unused;

  assign unused    = redirect_pc[0];
  assign head_is32 = (hw[0][1:0] == 2'b11);

  assign instr_valid = head_is32 ? (count >= 3'd2) : (count != 3'd0);
  assign fetch_ready = (count <= 3'd2);
  assign fire        = fetch_valid && fetch_ready;
  assign consumed    = (instr_valid && instr_ready) ? (head_is32 ? 3'd2 : 3'd1) : 3'd0;
  assign appended    = fire ? (drop_low ? 3'd1 : 3'd2) : 3'd0;
  assign kept        = count - consumed;

  rvc_decoder u_dec (
    .instr    (hw[0]),
    .is_rv64  (is_rv64),
    .expanded (dec_data),
    .illegal  (dec_illegal)
  );

  // Shift out consumed entries, then append the new halfwords behind the survivors.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      hw_next[i] = hw[2'(3'(i) + consumed)];
      if (fire && (3'(i) == kept))
        hw_next[i] = drop_low ? fetch_data[31:16] : fetch_data[15:0];
      if (fire && !drop_low && (3'(i) == kept + 3'd1))
        hw_next[i] = fetch_data[31:16];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) hw[i] <= 16'h0000;
      count    <= 3'd0;
      head_pc  <= {RESET_PC[XLEN-1:1], 1'b0};
      drop_low <= RESET_PC[1];
    end else if (redirect_valid) begin
      count    <= 3'd0;
      head_pc  <= {redirect_pc[XLEN-1:1], 1'b0};
      drop_low <= redirect_pc[1];
    end else begin
      for (int i = 0; i < 4; i++) hw[i] <= hw_next[i];
      count   <= kept + appended;
      head_pc <= head_pc + XLEN'({consumed, 1'b0});
      if (fire) drop_low <= 1'b0;
    end
  end

  assign instr_pc            = head_pc;
  assign instr_is_compressed = !head_is32;
  assign instr_illegal       = !head_is32 && dec_illegal;
  assign instr_data          = head_is32   ? {hw[1], hw[0]} :
                               dec_illegal ? {16'h0000, hw[0]} : dec_data;
endmodule

`default_nettype wire

// File: tb/tb_rvc_fetch_aligner.sv
// ============================================================================
// tb_rvc_fetch_aligner : directed scenarios plus randomized stream vs queue model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rvc_fetch_aligner;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        is_rv64 = 1'b0;
  logic        fetch_valid = 1'b0;
  logic        fetch_ready;
  logic [31:0] fetch_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_is_compressed;
  logic        instr_illegal;
  logic [66:0] obs;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        comp;
    logic        ill;
    int          len;
  } ins_t;

  // Known RV32C halfwords and their hand-expanded 32-bit forms.
  logic [15:0] pool_hw [15] = '{16'h0585, 16'h0505, 16'h4501, 16'h0000, 16'h852E,
                                16'h952E, 16'h4144, 16'hC144, 16'h050E, 16'hA011,
                                16'hC501, 16'h4522, 16'h8D0D, 16'h557D, 16'h6504};
  logic [31:0] pool_ex [15] = '{32'h00158593, 32'h00150513, 32'h00000513, 32'h00000000, 32'h00B00533,
                                32'h00B50533, 32'h00452483, 32'h00952223, 32'h00351513, 32'h0040006F,
                                32'h00050463, 32'h00812503, 32'h40B50533, 32'hFFF00513, 32'h00006504};
  logic        pool_il [15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  assign obs = {instr_valid, instr_data, instr_pc, instr_is_compressed, instr_illegal};

  rvc_fetch_aligner #(.XLEN(32), .RESET_PC(32'h8000_0000)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .is_rv64             (is_rv64),
    .fetch_valid         (fetch_valid),
    .fetch_ready         (fetch_ready),
    .fetch_data          (fetch_data),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .instr_valid         (instr_valid),
    .instr_ready         (instr_ready),
    .instr_data          (instr_data),
    .instr_pc            (instr_pc),
    .instr_is_compressed (instr_is_compressed),
    .instr_illegal       (instr_illegal)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic feed(input logic [31:0] w);
    fetch_valid = 1'b1;
    fetch_data  = w;
    step();
    fetch_valid = 1'b0;
  endtask

  task automatic consume();
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({instr_valid, fetch_ready, instr_pc} !== {1'b0, 1'b1, 32'h8000_0000}) begin
      errors++;
      $display("FAIL reset_state: got v=%b fr=%b pc=%h, want v=0 fr=1 pc=80000000", instr_valid, fetch_ready, instr_pc);
    end
    reset_n = 1'b1;
    feed(32'h00A0_0593);
    checks++;
    if (instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_midreset_valid: got %b want 1", instr_valid);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({instr_valid, fetch_ready, instr_pc} !== {1'b0, 1'b1, 32'h8000_0000}) begin
      errors++;
      $display("FAIL midstream_reset: got v=%b fr=%b pc=%h, want v=0 fr=1 pc=80000000", instr_valid, fetch_ready, instr_pc);
    end
    @(negedge clk);
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_word32();
    do_redirect(32'h8000_0000);
    checks++;
    if (fetch_ready !== 1'b1) begin
      errors++;
      $display("FAIL w32_fetch_ready: got %b want 1", fetch_ready);
    end
    feed(32'h00A0_0593);
    for (int n = 0; n < 2; n++) begin
      checks++;
      if (obs !== {1'b1, 32'h00A00593, 32'h8000_0000, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL w32_issue%0d: got %h want %h", n, obs, {1'b1, 32'h00A00593, 32'h8000_0000, 1'b0, 1'b0});
      end
      step();
    end
    consume();
    checks++;
    if ({instr_valid, instr_pc} !== {1'b0, 32'h8000_0004}) begin
      errors++;
      $display("FAIL w32_after: got v=%b pc=%h want v=0 pc=80000004", instr_valid, instr_pc);
    end
  endtask

  task automatic test_compressed();
    do_redirect(32'h8000_0000);
    feed(32'h0505_0585);
    checks++;
    if (obs !== {1'b1, 32'h00158593, 32'h8000_0000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL rvc_first: got %h want %h", obs, {1'b1, 32'h00158593, 32'h8000_0000, 1'b1, 1'b0});
    end
    consume();
    checks++;
    if (obs !== {1'b1, 32'h00150513, 32'h8000_0002, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL rvc_second: got %h want %h", obs, {1'b1, 32'h00150513, 32'h8000_0002, 1'b1, 1'b0});
    end
    consume();
  endtask

  task automatic test_straddle();
    do_redirect(32'h8000_0000);
    feed(32'h0513_4501);
    checks++;
    if (obs !== {1'b1, 32'h00000513, 32'h8000_0000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL straddle_cli: got %h want %h", obs, {1'b1, 32'h00000513, 32'h8000_0000, 1'b1, 1'b0});
    end
    consume();
    for (int n = 0; n < 3; n++) begin
      checks++;
      if ({instr_valid, instr_pc} !== {1'b0, 32'h8000_0002}) begin
        errors++;
        $display("FAIL straddle_stall%0d: got v=%b pc=%h want v=0 pc=80000002", n, instr_valid, instr_pc);
      end
      step();
    end
    feed(32'h0000_0055);
    checks++;
    if (obs !== {1'b1, 32'h00550513, 32'h8000_0002, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL straddle_w32: got %h want %h", obs, {1'b1, 32'h00550513, 32'h8000_0002, 1'b0, 1'b0});
    end
    consume();
  endtask

  task automatic test_redirect();
    do_redirect(32'h8000_0000);
    feed(32'h00A0_0593);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0102;
    fetch_valid    = 1'b1;
    fetch_data     = 32'h1234_0593;
    instr_ready    = 1'b1;
    step();
    redirect_valid = 1'b0;
    fetch_valid    = 1'b0;
    instr_ready    = 1'b0;
    checks++;
    if ({instr_valid, instr_pc} !== {1'b0, 32'h8000_0102}) begin
      errors++;
      $display("FAIL redirect_flush: got v=%b pc=%h want v=0 pc=80000102", instr_valid, instr_pc);
    end
    feed(32'h4501_FFFF);
    checks++;
    if (obs !== {1'b1, 32'h00000513, 32'h8000_0102, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL redirect_issue: got %h want %h", obs, {1'b1, 32'h00000513, 32'h8000_0102, 1'b1, 1'b0});
    end
    consume();
    checks++;
    if ({instr_valid, instr_pc, fetch_ready} !== {1'b0, 32'h8000_0104, 1'b1}) begin
      errors++;
      $display("FAIL redirect_drained: got v=%b pc=%h fr=%b want v=0 pc=80000104 fr=1", instr_valid, instr_pc, fetch_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ed [5] = '{32'h00150513, 32'h00158593, 32'h00000513, 32'h00B00533, 32'h40B50533};
    int  k;
    logic acc;
    do_redirect(32'h8000_0002);
    feed(32'h0505_0585);
    checks++;
    if (fetch_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_count1: got %b want 1", fetch_ready);
    end
    feed(32'h4501_0585);
    fetch_valid = 1'b1;
    fetch_data  = 32'h8D0D_852E;
    for (int n = 0; n < 3; n++) begin
      checks++;
      if ({fetch_ready, obs} !== {1'b0, 1'b1, 32'h00150513, 32'h8000_0002, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold%0d: got fr=%b %h want fr=0 %h", n, fetch_ready, obs, {1'b1, 32'h00150513, 32'h8000_0002, 1'b1, 1'b0});
      end
      step();
    end
    instr_ready = 1'b1;
    k = 0;
    for (int cyc = 0; cyc < 20 && k < 5; cyc++) begin
      if (instr_valid) begin
        checks++;
        if (obs !== {1'b1, ed[k], 32'h8000_0002 + 32'(2 * k), 1'b1, 1'b0}) begin
          errors++;
          $display("FAIL bp_release%0d: got %h want %h", k, obs, {1'b1, ed[k], 32'h8000_0002 + 32'(2 * k), 1'b1, 1'b0});
        end
        k++;
      end
      acc = fetch_valid && fetch_ready;
      step();
      if (acc) fetch_valid = 1'b0;
    end
    instr_ready = 1'b0;
    fetch_valid = 1'b0;
    checks++;
    if (k != 5) begin
      errors++;
      $display("FAIL bp_count: got %0d instructions want 5", k);
    end
  endtask

  task automatic test_illegal();
    is_rv64 = 1'b0;
    do_redirect(32'h8000_0000);
    feed(32'h6504_0000);
    checks++;
    if (obs !== {1'b1, 32'h00000000, 32'h8000_0000, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL illegal_zero: got %h want %h", obs, {1'b1, 32'h00000000, 32'h8000_0000, 1'b1, 1'b1});
    end
    consume();
    checks++;
    if (obs !== {1'b1, 32'h00006504, 32'h8000_0002, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL illegal_cld_rv32: got %h want %h", obs, {1'b1, 32'h00006504, 32'h8000_0002, 1'b1, 1'b1});
    end
    is_rv64 = 1'b1;
    #1;
    checks++;
    if (obs !== {1'b1, 32'h00853483, 32'h8000_0002, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL cld_rv64: got %h want %h", obs, {1'b1, 32'h00853483, 32'h8000_0002, 1'b1, 1'b0});
    end
    @(negedge clk);
    consume();
    is_rv64 = 1'b0;
  endtask

  task automatic test_random();
    ins_t        exq [$];
    logic [15:0] hq  [$];
    logic [31:0] pc, w;
    int          idx, widx, inq, nwords, k, cyc;
    logic        exp_v, rdy, fv, cons, acc;
    pc = 32'h8000_1002;
    hq.push_back(16'hFFFF);
    while (hq.size() < 160) begin
      if ($urandom_range(0, 3) == 0) begin
        w = $urandom | 32'h3;
        hq.push_back(w[15:0]);
        hq.push_back(w[31:16]);
        exq.push_back(ins_t'{pc, w, 1'b0, 1'b0, 2});
        pc += 32'd4;
      end else begin
        k = $urandom_range(0, 14);
        hq.push_back(pool_hw[k]);
        exq.push_back(ins_t'{pc, pool_ex[k], 1'b1, pool_il[k], 1});
        pc += 32'd2;
      end
    end
    if (hq.size() % 2 == 1) begin
      hq.push_back(16'h4501);
      exq.push_back(ins_t'{pc, 32'h00000513, 1'b1, 1'b0, 1});
    end
    nwords = hq.size() / 2;
    is_rv64 = 1'b0;
    do_redirect(32'h8000_1002);
    idx = 0; widx = 0; inq = 0; cyc = 0;
    while (idx < exq.size() && cyc < 3000) begin
      exp_v = (inq >= exq[idx].len);
      checks++;
      if (fetch_ready !== (inq <= 2)) begin
        errors++;
        $display("FAIL rnd_fetch_ready cyc%0d: got %b want %b", cyc, fetch_ready, inq <= 2);
      end
      checks++;
      if (instr_valid !== exp_v) begin
        errors++;
        $display("FAIL rnd_valid cyc%0d: got %b want %b", cyc, instr_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (obs !== {1'b1, exq[idx].data, exq[idx].pc, exq[idx].comp, exq[idx].ill}) begin
          errors++;
          $display("FAIL rnd_instr%0d: got %h want %h", idx, obs, {1'b1, exq[idx].data, exq[idx].pc, exq[idx].comp, exq[idx].ill});
        end
      end
      rdy = ($urandom_range(0, 3) != 0);
      fv  = (widx < nwords) && ($urandom_range(0, 3) != 0);
      instr_ready = rdy;
      fetch_valid = fv;
      fetch_data  = fv ? {hq[2 * widx + 1], hq[2 * widx]} : $urandom;
      cons = exp_v && rdy;
      acc  = fv && (inq <= 2);
      step();
      cyc++;
      if (cons) begin
        inq -= exq[idx].len;
        idx++;
      end
      if (acc) begin
        inq += (widx == 0) ? 1 : 2;
        widx++;
      end
    end
    instr_ready = 1'b0;
    fetch_valid = 1'b0;
    checks++;
    if (idx != exq.size()) begin
      errors++;
      $display("FAIL rnd_timeout: issued %0d of %0d instructions", idx, exq.size());
    end
  endtask

  initial begin
    test_reset();
    test_word32();
    test_compressed();
    test_straddle();
    test_redirect();
    test_back_to_back();
    test_illegal();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end
endmodule

`default_nettype wire

// File: doc/rvc_fetch_aligner.md
# rvc_fetch_aligner

Sits between the instruction-fetch stream and the decode stage, and sequences the RVC decompressor. It buffers 32-bit fetch words as a halfword queue and finds instruction boundaries for mixed 16/32-bit code, including 32-bit instructions that straddle word boundaries. Compressed halfwords go through an internal `rvc_decoder` instance. Decode receives one aligned, expanded 32-bit instruction per handshake, with its PC and a compressed flag.

## Interface
- `XLEN`, 32: PC width and decoder width (32 or 64).
- `RESET_PC`, 32'h8000_0000 (zero-extended to XLEN): first instruction address; bit 0 is ignored.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `is_rv64`  in  1  forwarded to the decoder's RV64C selection.
- `fetch_valid`  in  1  `fetch_data` holds the next sequential aligned word.
- `fetch_ready`  out  1  aligner can accept a word this cycle.
- `fetch_data`  in  32  little-endian word; halfword 0 = bits [15:0].
- `redirect_valid`  in  1  flush and restart at `redirect_pc` (branch, trap, etc.).
- `redirect_pc`  in  XLEN  new PC; bit 0 is ignored.
- `instr_valid`  out  1  `instr_*` outputs hold a complete instruction.
- `instr_ready`  in  1  decode consumes the instruction.
- `instr_data`  out  32  expanded instruction.
- `instr_pc`  out  XLEN  address of the instruction's first halfword.
- `instr_is_compressed`  out  1  the source instruction was 16-bit.
- `instr_illegal`  out  1  the decoder flagged the compressed halfword illegal.

## Operation
- State:
  - 4-entry halfword queue `hw[0..3]` with `count` (0..4).
  - `head_pc`: address of `hw[0]`.
  - `drop_low` flag.
- Acceptance: `fetch_ready = (count <= 2)`. It depends only on registered state, never on `instr_ready`.
- On a fetch handshake:
  - Normally append both halfwords, count += 2.
  - If `drop_low` = 1, append only the upper halfword, count += 1, and clear `drop_low`.
- Head classification: `hw[0][1:0] != 2'b11` means a 16-bit instruction, otherwise 32-bit.
- `instr_valid` (combinational from registers):
  - 16-bit head: `count >= 1`.
  - 32-bit head: `count >= 2`.
- 16-bit instruction outputs:
  - `instr_data` = decoder output; `instr_is_compressed` = 1.
  - If the decoder flags illegal: `instr_illegal` = 1 and `instr_data = {16'h0000, hw[0]}`.
- 32-bit instruction outputs: `instr_data = {hw[1], hw[0]}`; `instr_is_compressed` = 0; `instr_illegal` = 0.
- `instr_pc = head_pc`.
- On a consume handshake:
  - Shift the queue by 1 or 2 halfwords.
  - `head_pc += 2` or `+= 4`, wrapping modulo 2^XLEN.
- Simultaneous consume and fetch: shift first, then append after the remaining entries. Next count = count − consumed + appended. Count never exceeds 4.
- Redirect has priority over both handshakes in the same cycle:
  - `count` ← 0 and `head_pc` ← `{redirect_pc[XLEN-1:1], 1'b0}`.
  - `drop_low` ← `redirect_pc[1]`.
  - Any fetch word presented that cycle is discarded.
  - The consume handshake is ignored.
  - Upstream must supply the word at `redirect_pc & ~3` next.
- `instr_valid` is 0 in the cycle after a redirect.
- Reset (asynchronous, `reset_n` low):
  - `count` = 0, `head_pc` = RESET_PC with bit 0 cleared, `drop_low` = RESET_PC[1].
  - Outputs: `instr_valid` = 0, `fetch_ready` = 1, `instr_pc` = RESET_PC with bit 0 cleared.
  - Reset asserted mid-stream discards all queued halfwords.

## Timing
- Fetch-to-issue latency: a word accepted in cycle N can be issued in cycle N+1, with no extra pipeline stage.
- Throughput: one instruction per cycle when upstream supplies one word per cycle.
  - A sustained 16-bit stream fills the queue, and `fetch_ready` deasserts at count 3–4.
- Valid/ready rules:
  - `instr_valid`, once asserted, holds with stable outputs until consumed or redirected.
  - `fetch_data` need only be held while `fetch_valid && !fetch_ready`.
- Straddling 32-bit instruction: upper half at `head_pc+2` in the next word.
  - `instr_valid` stays 0 with count = 1 until that word arrives. This is the only underflow stall.
- Outputs are undefined-but-stable when `instr_valid` = 0, except `instr_pc`, which always equals `head_pc`.

## Test plan
- Reset to RESET_PC = 0x80000000, then feed 0x00A00593 (32-bit li).
  - `fetch_ready` = 1.
  - Next cycle: `instr_valid` = 1, `instr_data` = 0x00A00593, `instr_pc` = 0x80000000, `instr_is_compressed` = 0.
- Feed 0x0505_0585 (two halfwords: 0x0585 = C.ADDI x11,1; 0x0505 = C.ADDI x10,1).
  - Issues 0x00158593 @0x80000000, then 0x00150513 @0x80000002, both with compressed = 1.
- Straddle: feed 0x0513_4501, then 0x0000_0055.
  - First issue: C.LI x10,0 (0x00000513) @PC.
  - Second issue: 32-bit 0x00550513 @PC+2, only after the second word arrives.
- Redirect to 0x80000102 while `instr_valid` = 1 and a fetch handshake occurs in the same cycle; then feed 0x4501_FFFF.
  - Queue is flushed and the fetch word discarded.
  - The 0xFFFF half is dropped; issues 0x00000513 @0x80000102.
- Backpressure: hold `instr_ready` = 0 and stream 16-bit words.
  - `fetch_ready` falls once count reaches 3.
  - No halfword is lost or duplicated; PCs increment by 2 when released.
- Illegal halfword 0x0000: `instr_illegal` = 1, `instr_data` = 0x00000000, `instr_is_compressed` = 1.
  - Repeat with `is_rv64` = 1 and 0x6504 (C.LD x9,8(x10)) → 0x00853483.
